// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to instruction memory and buffers
// {pc+4, instr} pairs for IF/ID. Taken-branch redirects flush the queue and drop any in-flight fetch.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_add_4_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]   r_req_addr, w_req_addr_nxt;
    logic [PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc4   [DEPTH];
    logic [31:0]   r_instr [DEPTH];

    logic          w_pop, w_push, w_full;
    logic [31:0]   w_pc_next;
    logic [CW-1:0] w_cnt_after;

    assign w_pop       = out_valid_o & out_ready_i;
    assign w_full      = (r_count == DEPTH_C);
    assign w_pc_next   = r_fetch_pc + 32'd4;
    // Occupancy after this cycle's push; count is always below DEPTH while in WAIT.
    assign w_cnt_after = r_count + CW'(1) - CW'(w_pop);

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_req_addr_nxt = r_req_addr;
        w_push         = 1'b0;
        if (redirect_i) begin
            w_fetch_pc_nxt = redirect_pc_i;
            if (r_state == S_IDLE) begin
                if (!imem_ack_i) begin
                    w_state_nxt    = S_WAIT;
                    w_req_addr_nxt = redirect_pc_i;
                end
            end else begin
                // An unacked request must complete at its old address before the target is issued.
                w_state_nxt = imem_ack_i ? S_IDLE : S_DROP;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_full) begin
                        w_state_nxt    = S_WAIT;
                        w_req_addr_nxt = r_fetch_pc;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = w_pc_next;
                        if (w_cnt_after < DEPTH_C) w_req_addr_nxt = w_pc_next;
                        else                       w_state_nxt    = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (imem_ack_i) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_req_addr <= w_req_addr_nxt;
            if (redirect_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Entry storage needs no reset; head outputs are masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (w_push && !redirect_i) begin
            r_pc4[r_wr_ptr]   <= w_pc_next;
            r_instr[r_wr_ptr] <= imem_data_i;
        end
    end

    assign imem_req_o     = (r_state != S_IDLE);
    assign imem_addr_o    = r_req_addr;
    assign out_valid_o    = (r_count != '0);
    assign out_instr_o    = out_valid_o ? r_instr[r_rd_ptr] : 32'd0;
    assign out_pc_add_4_o = out_valid_o ? r_pc4[r_rd_ptr]   : 32'd0;
endmodule
